// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Constants shared by the HI/LO multiply/divide unit and the instruction
// decoder: the 4-bit mult/div opcodes, the FSM state encoding, and small
// opcode-classification helpers.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    // Encodings above MD_MSUBU are unused and behave like MD_NONE.
    function automatic logic md_valid(input logic [3:0] op);
        return (op != MD_NONE) && (op <= MD_MSUBU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Issue/result bundle between the decoder/EX stage (master) and the
// multiply/divide unit (slave).
//   start, op, a, b, flush : master -> slave issue controls and operands
//   busy, done, hi, lo     : slave -> master status and committed HI/LO
// -----------------------------------------------------------------------------
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_div_arith.sv
// -----------------------------------------------------------------------------
// mult_div_arith
// Purely combinational datapath: computes the full 2*WIDTH {shi, slo} result
// an operation will commit, from the opcode, operands and issue-time HI/LO.
//   op      : mult/div opcode
//   a, b    : rs / rt operands
//   hi, lo  : HI/LO values current at issue (accumulate base, div-by-zero keep)
//   shi,slo : result to be latched into the shadow registers
// -----------------------------------------------------------------------------
module mult_div_arith
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] shi,
    output logic [WIDTH-1:0] slo
);
    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    acc;
    logic [W2-1:0]    prod_s;
    logic [W2-1:0]    prod_u;
    logic [W2-1:0]    result;
    logic [WIDTH-1:0] q_s, r_s, q_u, r_u;
    logic             div_zero;
    logic             div_ovf;

    assign acc = {hi, lo};

    // Multiplying the sign-extended operands in 2*WIDTH bits gives the signed
    // product modulo 2^(2*WIDTH), which is all that is ever kept.
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    assign div_zero = (b == '0);
    // Most-negative / -1 does not fit; handled explicitly rather than relying
    // on the wrap behaviour of the divider.
    assign div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    always_comb begin
        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (!div_zero) begin
            q_u = a / b;
            r_u = a % b;
            if (div_ovf) begin
                q_s = a;
                r_s = '0;
            end else begin
                q_s = $signed(a) / $signed(b);
                r_s = $signed(a) % $signed(b);
            end
        end
    end

    always_comb begin
        result = acc;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_MADD:  result = acc + prod_s;
            MD_MADDU: result = acc + prod_u;
            MD_MSUB:  result = acc - prod_s;
            MD_MSUBU: result = acc - prod_u;
            MD_DIV:   result = div_zero ? acc : {r_s, q_s};
            MD_DIVU:  result = div_zero ? acc : {r_u, q_u};
            default:  result = acc;
        endcase
    end

    assign shi = result[W2-1:WIDTH];
    assign slo = result[WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle HI/LO multiply/divide unit for the EX stage. The result is
// computed at issue into shadow registers, then committed to HI/LO after a
// fixed latency so that timing matches a real iterative unit.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of mult_div_unit_if (start/op/a/b/flush in,
//             busy/done/hi/lo out)
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic            clk,
    input logic            reset_n,
    mult_div_unit_if.slave bus
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

    md_state_t        state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] shi_reg, shi_next;
    logic [WIDTH-1:0] slo_reg, slo_next;
    logic [WIDTH-1:0] hi_reg, hi_next;
    logic [WIDTH-1:0] lo_reg, lo_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] arith_hi, arith_lo;

    mult_div_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .op  (bus.op),
        .a   (bus.a),
        .b   (bus.b),
        .hi  (hi_reg),
        .lo  (lo_reg),
        .shi (arith_hi),
        .slo (arith_lo)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            shi_reg   <= '0;
            slo_reg   <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            shi_reg   <= shi_next;
            slo_reg   <= slo_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shi_next   = shi_reg;
        slo_next   = slo_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.flush && md_valid(bus.op)) begin
                    if (bus.op == MD_MTHI) begin
                        hi_next = bus.a;
                    end else if (bus.op == MD_MTLO) begin
                        lo_next = bus.a;
                    end else begin
                        shi_next   = arith_hi;
                        slo_next   = arith_lo;
                        count_next = md_is_div(bus.op) ? DIV_LOAD : MULT_LOAD;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                // Flush wins over a same-cycle commit.
                if (bus.flush) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (count_reg == '0) begin
                    hi_next    = shi_reg;
                    lo_next    = slo_reg;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule
